regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/legv8_pkg.sv | 16 +
 rtl/regfile_mux.sv | 13 +
 rtl/regfile.sv | 79 +++++++
 tb/tb_regfile.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath constants: register-address width, register count and the XZR encoding.
package legv8_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t XZR_ADDR = 5'd31;

    // Address 31 reads as zero and swallows writes.
    function automatic logic is_xzr(input reg_addr_t addr);
        return addr == XZR_ADDR;
    endfunction

endpackage

// File: rtl/regfile_mux.sv
// Generic 2:1 data mux used for the register-file write-through path.
module mux #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/regfile.sv
// LEGv8 register file: 31 stored registers plus XZR, two combinational read ports, one write port.
// Optional same-cycle write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile
    import legv8_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] ra1,
    input  logic [REG_ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]      rd1,
    output logic [WIDTH-1:0]      rd2,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]      wd
);

    localparam int STORED_REGS = NUM_REGS - 1;

    logic [WIDTH-1:0]       regs_q [STORED_REGS];
    logic [STORED_REGS-1:0] wr_sel_d;
    logic [WIDTH-1:0]       stored1;
    logic [WIDTH-1:0]       stored2;

    // One-hot write select; wa=31 matches no stored register, so XZR writes vanish.
    always_comb begin
        wr_sel_d = '0;
        if (we) begin
            for (int i = 0; i < STORED_REGS; i++) begin
                wr_sel_d[i] = (wa == REG_ADDR_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STORED_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STORED_REGS; i++) begin
                if (wr_sel_d[i]) begin
                    regs_q[i] <= wd;
                end
            end
        end
    end

    assign stored1 = is_xzr(ra1) ? '0 : regs_q[ra1];
    assign stored2 = is_xzr(ra2) ? '0 : regs_q[ra2];

`ifdef REGFILE_BYPASS_EN
    logic fwd1;
    logic fwd2;

    // Forward the in-flight write so write-back and decode can share a cycle.
    assign fwd1 = we && (wa == ra1) && !is_xzr(wa);
    assign fwd2 = we && (wa == ra2) && !is_xzr(wa);

    mux #(.WIDTH(WIDTH)) u_mux_rd1 (
        .a_i   (stored1),
        .b_i   (wd),
        .sel_i (fwd1),
        .y_o   (rd1)
    );

    mux #(.WIDTH(WIDTH)) u_mux_rd2 (
        .a_i   (stored2),
        .b_i   (wd),
        .sel_i (fwd2),
        .y_o   (rd2)
    );
`else
    assign rd1 = stored1;
    assign rd2 = stored2;
`endif

endmodule

// File: tb/tb_regfile.sv
// Directed scoreboard bench for regfile: expected read values are queued as stimulus is driven
// and compared once the combinational outputs settle. Honors REGFILE_BYPASS_EN for hazard expectations.
module tb_regfile;

    localparam int WIDTH = 64;

    typedef struct {
        string            tag;
        int               port;
        logic [WIDTH-1:0] value;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [4:0]       ra1;
    logic [4:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             we;
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    regfile #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (we),
        .wa    (wa),
        .wd    (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic weV, input logic [4:0] waV, input logic [WIDTH-1:0] wdV,
                                 input logic [4:0] ra1V, input logic [4:0] ra2V);
        we  = weV;
        wa  = waV;
        wd  = wdV;
        ra1 = ra1V;
        ra2 = ra2V;
    endtask

    task automatic expectRead(input string tag, input int port, input logic [WIDTH-1:0] value);
        exp_t e;
        e.tag   = tag;
        e.port  = port;
        e.value = value;
        sb.push_back(e);
    endtask

    // Settle the combinational read path, then drain the scoreboard.
    task automatic checkOutput();
        exp_t             e;
        logic [WIDTH-1:0] observed;
        #1;
        while (sb.size() > 0) begin
            e        = sb.pop_front();
            observed = (e.port == 1) ? rd1 : rd2;
            checks++;
            assert (observed === e.value) else begin
                errors++;
                $error("[TB] FAIL %s: observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] hazardExp;

        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd30);
        #2;
        expectRead("reset_rd1_x0", 1, '0);
        expectRead("reset_rd2_x30", 2, '0);
        checkOutput();

        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release must accept a write.
        applyStimulus(1'b1, 5'd7, 64'h0000_0000_0000_0777, 5'd7, 5'd7);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 5'd7, 5'd7);
        expectRead("first_write_x7", 1, 64'h777);
        checkOutput();

        // Asynchronous clear mid-cycle.
        applyStimulus(1'b1, 5'd5, 64'h0000_0000_DEAD_BEEF, 5'd5, 5'd5);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 5'd5, 5'd7);
        expectRead("x5_written", 1, 64'hDEAD_BEEF);
        checkOutput();
        #1;
        rst_n = 1'b0;
        expectRead("async_clear_x5", 1, '0);
        expectRead("async_clear_x7", 2, '0);
        checkOutput();

        // Writes while reset is held are lost.
        applyStimulus(1'b1, 5'd6, 64'h6666, 5'd6, 5'd6);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 5'd6, 5'd6);
        #1;
        rst_n = 1'b1;
        expectRead("write_in_reset_lost", 1, '0);
        checkOutput();

        // Write then hold.
        applyStimulus(1'b1, 5'd9, 64'h1234_5678_9ABC_DEF0, 5'd0, 5'd9);
        tick();
        applyStimulus(1'b0, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 5'd9);
        expectRead("write_x9", 2, 64'h1234_5678_9ABC_DEF0);
        checkOutput();
        tick();
        expectRead("we0_hold_x9", 2, 64'h1234_5678_9ABC_DEF0);
        checkOutput();

        // Same-cycle read of the register being written.
        applyStimulus(1'b1, 5'd3, 64'h10, 5'd3, 5'd3);
        tick();
`ifdef REGFILE_BYPASS_EN
        hazardExp = 64'h20;
`else
        hazardExp = 64'h10;
`endif
        applyStimulus(1'b1, 5'd3, 64'h20, 5'd3, 5'd3);
        expectRead("hazard_pre_edge_rd1", 1, hazardExp);
        expectRead("hazard_pre_edge_rd2", 2, hazardExp);
        checkOutput();
        tick();
        applyStimulus(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd3);
        expectRead("xzr_no_bypass", 1, '0);
        expectRead("hazard_post_edge", 2, 64'h20);
        checkOutput();
        tick();
        applyStimulus(1'b0, 5'd0, '0, 5'd31, 5'd3);
        expectRead("xzr_after_write", 1, '0);
        expectRead("x3_kept_after_xzr", 2, 64'h20);
        checkOutput();

        // Dual read and aliasing.
        applyStimulus(1'b1, 5'd1, 64'hA, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b1, 5'd2, 64'hB, 5'd0, 5'd0);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 5'd2, 5'd1);
        expectRead("dual_rd1_x2", 1, 64'hB);
        expectRead("dual_rd2_x1", 2, 64'hA);
        checkOutput();
        applyStimulus(1'b0, 5'd0, '0, 5'd1, 5'd1);
        expectRead("alias_rd1_x1", 1, 64'hA);
        expectRead("alias_rd2_x1", 2, 64'hA);
        checkOutput();

        // Walking write of every stored register.
        for (int i = 0; i < 31; i++) begin
            applyStimulus(1'b1, 5'(i), WIDTH'(i + 1), 5'd0, 5'd0);
            tick();
        end
        applyStimulus(1'b0, 5'd0, '0, 5'd0, 5'd0);
        for (int i = 0; i < 31; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(30 - i);
            expectRead($sformatf("walk_rd1_x%0d", i), 1, WIDTH'(i + 1));
            expectRead($sformatf("walk_rd2_x%0d", 30 - i), 2, WIDTH'(31 - i));
            checkOutput();
        end

        // XZR write must leave every stored register alone.
        applyStimulus(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 5'd31, 5'd31);
        expectRead("xzr_rd1", 1, '0);
        expectRead("xzr_rd2", 2, '0);
        checkOutput();
        for (int i = 0; i < 31; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(i);
            expectRead($sformatf("xzr_keep_rd1_x%0d", i), 1, WIDTH'(i + 1));
            expectRead($sformatf("xzr_keep_rd2_x%0d", i), 2, WIDTH'(i + 1));
            checkOutput();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
